// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, truncating (C) semantics.
// Operands load over a shared W-bit bus; restoring shift/subtract core with sign fix-up.
module seq_signed_divider #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned CntW = $clog2(W) + 1;
  localparam logic [W-1:0] QMaxPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMaxNeg = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLdl,
    StLdd,
    StChk,
    StDiv,
    StFix,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [2*W-1:0] r_dvd;
  logic [W-1:0]   r_dvs;
  logic [W:0]     r_dvs_mag;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_qsh;
  logic [CntW-1:0] r_cnt;
  logic           r_sign_q;
  logic           r_sign_r;

  logic [W-1:0]   r_quotient;
  logic [W-1:0]   r_remainder;
  logic           r_busy;
  logic           r_done;
  logic           r_div_by_zero;
  logic           r_overflow;

  logic [2*W-1:0] w_dvd_mag;
  logic [W:0]     w_dvs_ext;
  logic [W:0]     w_dvs_mag;
  logic           w_dvs_zero;
  logic           w_chk_ovf;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic           w_trial_ok;
  logic           w_fix_ovf;
  logic           w_last_iter;

  // Magnitudes: divisor gets an extra bit so that -2^(W-1) stays representable.
  always_comb begin
    w_dvd_mag  = r_dvd[2*W-1] ? -r_dvd : r_dvd;
    w_dvs_ext  = {r_dvs[W-1], r_dvs};
    w_dvs_mag  = r_dvs[W-1] ? -w_dvs_ext : w_dvs_ext;
    w_dvs_zero = (r_dvs == '0);
    // High half >= divisor means the quotient magnitude would need more than W bits.
    w_chk_ovf  = ({1'b0, w_dvd_mag[2*W-1:W]} >= w_dvs_mag);
  end

  always_comb begin
    w_shift     = {r_rem, r_qsh[W-1]};
    w_trial_ok  = (w_shift >= r_dvs_mag);
    w_trial     = w_shift - r_dvs_mag;
    w_last_iter = (r_cnt == CntW'(1));
    w_fix_ovf   = r_sign_q ? (r_qsh > QMaxNeg) : (r_qsh > QMaxPos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) w_state_next = StLdl;
      end
      StLdl: w_state_next = StLdd;
      StLdd: w_state_next = StChk;
      StChk: begin
        if (w_dvs_zero || w_chk_ovf) w_state_next = StDone;
        else                         w_state_next = StDiv;
      end
      StDiv: begin
        if (w_last_iter) w_state_next = StFix;
      end
      StFix:   w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_dvs_mag     <= '0;
      r_rem         <= '0;
      r_qsh         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_dvd[2*W-1:W] <= data_in;
            r_done         <= 1'b0;
            r_div_by_zero  <= 1'b0;
            r_overflow     <= 1'b0;
            r_busy         <= 1'b1;
          end
        end
        StLdl: r_dvd[W-1:0] <= data_in;
        StLdd: r_dvs <= data_in;
        StChk: begin
          r_sign_q  <= r_dvd[2*W-1] ^ r_dvs[W-1];
          r_sign_r  <= r_dvd[2*W-1];
          r_dvs_mag <= w_dvs_mag;
          r_rem     <= w_dvd_mag[2*W-1:W];
          r_qsh     <= w_dvd_mag[W-1:0];
          r_cnt     <= CntW'(W);
          if (w_dvs_zero) begin
            r_div_by_zero <= 1'b1;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
          end else if (w_chk_ovf) begin
            r_overflow    <= 1'b1;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        StDiv: begin
          // Partial remainder stays below |divisor| <= 2^(W-1), so W bits suffice.
          r_rem <= w_trial_ok ? w_trial[W-1:0] : w_shift[W-1:0];
          r_qsh <= {r_qsh[W-2:0], w_trial_ok};
          r_cnt <= r_cnt - CntW'(1);
        end
        StFix: begin
          if (w_fix_ovf) begin
            r_overflow  <= 1'b1;
            r_quotient  <= '0;
            r_remainder <= '0;
          end else begin
            r_quotient  <= r_sign_q ? -r_qsh : r_qsh;
            r_remainder <= r_sign_r ? -r_rem : r_rem;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider (W=16).
module tb_seq_signed_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int checks;
  int errors;

  logic e0_busy, e0_done, e0_dbz, e0_ovf;
  int   lat;

  seq_signed_divider #(.W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives E0..E2; returns #1 after E2 with flags sampled #1 after E0.
  task automatic load(input logic [31:0] dvd, input logic [15:0] dvs);
    start   = 1'b1;
    data_in = dvd[31:16];
    @(posedge clk); #1;
    e0_busy = busy; e0_done = done; e0_dbz = div_by_zero; e0_ovf = overflow;
    start   = 1'b0;
    data_in = dvd[15:0];
    @(posedge clk); #1;
    data_in = dvs;
    @(posedge clk); #1;
    data_in = 16'($urandom);
  endtask

  // Counts edges after E2 until done is seen; 'already' edges were spent by the caller.
  task automatic wait_done(input int already, output int n);
    n = already;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within %0d edges", n);
      n = -1;
    end
  endtask

  task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs);
    load(dvd, dvs);
    wait_done(0, lat);
  endtask

  task automatic check_res(input string name, input logic [15:0] q, input logic [15:0] r,
                           input logic dbz, input logic ovf, input int exp_lat);
    checks++;
    if ({quotient, remainder} !== {q, r}) begin
      errors++;
      $display("FAIL %s q/r: got %h/%h want %h/%h", name, quotient, remainder, q, r);
    end
    checks++;
    if ({div_by_zero, overflow, busy} !== {dbz, ovf, 1'b0}) begin
      errors++;
      $display("FAIL %s dbz/ovf/busy: got %b%b%b want %b%b0", name, div_by_zero, overflow,
               busy, dbz, ovf);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 36'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h/%h %b%b%b%b want all zero", quotient, remainder,
               busy, done, div_by_zero, overflow);
    end
  endtask

  task automatic test_basic();
    load(32'h0000_0064, 16'h0007);
    checks++;
    if ({e0_busy, e0_done} !== 2'b10) begin
      errors++;
      $display("FAIL basic accept busy/done: got %b%b want 10", e0_busy, e0_done);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic busy after E2: got %b want 1", busy);
    end
    wait_done(0, lat);
    check_res("100/7", 16'h000E, 16'h0002, 1'b0, 1'b0, 18);
    run_div(32'h0012_3456, 16'h0100);
    check_res("0x123456/256", 16'h1234, 16'h0056, 1'b0, 1'b0, 18);
  endtask

  task automatic test_signs();
    logic [31:0] dvd [3] = '{32'hFFFF_FF9C, 32'h0000_0064, 32'hFFFF_FF9C};
    logic [15:0] dvs [3] = '{16'h0007, 16'hFFF9, 16'hFFF9};
    logic [15:0] eq  [3] = '{16'hFFF2, 16'hFFF2, 16'h000E};
    logic [15:0] er  [3] = '{16'hFFFE, 16'h0002, 16'hFFFE};
    for (int i = 0; i < 3; i++) begin
      run_div(dvd[i], dvs[i]);
      check_res($sformatf("sign%0d", i), eq[i], er[i], 1'b0, 1'b0, 18);
    end
  endtask

  task automatic test_div_zero();
    run_div(32'h1234_5678, 16'h0000);
    check_res("divzero", 16'h0000, 16'h0000, 1'b1, 1'b0, 1);
    load(32'h0000_0064, 16'h0007);
    checks++;
    if ({e0_busy, e0_done, e0_dbz, e0_ovf} !== 4'b1000) begin
      errors++;
      $display("FAIL divzero clear at accept: got %b%b%b%b want 1000", e0_busy, e0_done,
               e0_dbz, e0_ovf);
    end
    wait_done(0, lat);
    check_res("after divzero", 16'h000E, 16'h0002, 1'b0, 1'b0, 18);
  endtask

  task automatic test_overflow();
    logic [31:0] dvd [4] = '{32'h0001_0000, 32'h0000_8000, 32'hFFFF_8000, 32'h8000_0000};
    logic [15:0] dvs [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic [15:0] eq  [4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
    logic        eo  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          el  [4] = '{1, 18, 18, 1};
    for (int i = 0; i < 4; i++) begin
      run_div(dvd[i], dvs[i]);
      check_res($sformatf("ovf%0d", i), eq[i], 16'h0000, 1'b0, eo[i], el[i]);
    end
  endtask

  task automatic test_mid_reset();
    load(32'h0000_0064, 16'h0007);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 36'd0) begin
      errors++;
      $display("FAIL mid reset outputs: got %h/%h %b%b%b%b want all zero", quotient,
               remainder, busy, done, div_by_zero, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL post reset idle busy/done: got %b%b want 00", busy, done);
    end
    run_div(32'hFFFF_FC18, 16'h0003);
    check_res("after reset", 16'hFEB3, 16'hFFFF, 1'b0, 1'b0, 18);
  endtask

  task automatic test_start_during_div();
    load(32'h0000_0064, 16'h0007);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start   = i[0];
      data_in = 16'($urandom);
    end
    start = 1'b0;
    wait_done(6, lat);
    check_res("start in div", 16'h000E, 16'h0002, 1'b0, 1'b0, 18);
  endtask

  task automatic test_start_in_done();
    load(32'hFFFF_FC18, 16'h0003);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy, done} !== {16'h000E, 16'h0002, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL held result: got %h/%h busy %b done %b want 000e/0002 busy 1 done 0",
               quotient, remainder, busy, done);
    end
    wait_done(8, lat);
    check_res("start in done", 16'hFEB3, 16'hFFFF, 1'b0, 1'b0, 18);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, done} !== {16'hFEB3, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL done hold: got %h/%h done %b want feb3/ffff done 1", quotient,
               remainder, done);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = 16'h0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_mid_reset();
    test_start_during_div();
    test_start_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Inverse companion of the team's sequential signed Booth multiplier.
- Divides a signed 2W-bit dividend by a signed W-bit divisor, producing a signed W-bit quotient and a signed W-bit remainder (truncating division, C semantics).
- Operands arrive on the same shared W-bit data_in bus, one word per cycle, using the multiplier's start/done handshake.
- Internally a datapath plus controller: absolute-value conversion, 16-step unsigned restoring shift/subtract, then sign fix-up.

Parameters:
- W, 16, operand, quotient and remainder width. Dividend is 2W bits. Iteration counter is clog2(W)+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin load sequence; sampled only in IDLE or DONE.
- data_in  input  W  signed operand bus. Carries dividend[2W-1:W], then dividend[W-1:0], then the divisor, on consecutive cycles.
- quotient  output  W  signed quotient, registered.
- remainder  output  W  signed remainder, registered.
- busy  output  1  high from the start-accept edge until the DONE-entry edge.
- done  output  1  result valid; held high until the next start is accepted.
- div_by_zero  output  1  error flag, valid while done is high.
- overflow  output  1  error flag, valid while done is high.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset is asynchronous, applies at any time, including mid-division, and discards the in-flight operation.
- States: IDLE, LDL, LDD, CHK, DIV, FIX, DONE.
- IDLE/DONE, start=1 at edge E0:
  - latch data_in into the dividend high half;
  - clear done and both error flags;
  - set busy;
  - go to LDL.
- IDLE/DONE, start=0: hold state. Outputs hold their last values.
- LDL (edge E1): latch the dividend low half; go to LDD.
- LDD (edge E2): latch the divisor; go to CHK.
- CHK (edge E3):
  - compute magnitudes |dividend| (2W bits unsigned) and |divisor| (W+1 bits, so that -2^(W-1) is representable);
  - record sign_q = dividend[2W-1] XOR divisor[W-1] and sign_r = dividend[2W-1];
  - divisor == 0: div_by_zero=1, quotient=remainder=0, go to DONE;
  - else if |dividend|[2W-1:W] >= |divisor| (quotient magnitude >= 2^W): overflow=1, quotient=remainder=0, go to DONE;
  - else load the counter with W and go to DIV.
- DIV, one iteration per cycle for W cycles (edges E4..E3+W):
  - shift the {partial remainder (W+1 bits), dividend} pair left by 1;
  - trial-subtract |divisor|;
  - if the result is non-negative, keep it and set quotient bit 1; else restore and set the bit to 0;
  - decrement the counter; exit to FIX when the counter reaches 0.
- FIX (edge E4+W):
  - apply signs: quotient = sign_q ? -qmag : qmag; remainder = sign_r ? -rmag : rmag;
  - range check: overflow if qmag > 2^(W-1)-1 with sign_q=0, or qmag > 2^(W-1) with sign_q=1; on overflow, quotient=remainder=0;
  - go to DONE.
- DONE: done=1, busy=0, results held stable.
- Latency for W=16:
  - normal: done rises at E20, i.e. 18 edges after the divisor edge E2;
  - error exit: done rises at E3.
- start while busy: ignored, no effect on the operation.
- data_in: ignored outside the three load cycles.
- Remainder always satisfies |remainder| < |divisor| and takes the dividend's sign; a zero remainder is 0, never a negative zero.

Test Plan:
- 100 / 7: dividend 0x0000_0064, divisor 0x0007 -> quotient 0x000E, remainder 0x0002, done at E20, flags 0; busy high E0..E19.
- Sign combinations:
  - -100/7 -> q 0xFFF2, r 0xFFFE;
  - 100/-7 -> q 0xFFF2, r 0x0002;
  - -100/-7 -> q 0x000E, r 0xFFFE.
- Divide by zero: dividend 0x1234_5678, divisor 0x0000 -> div_by_zero=1, q=r=0, done at E3; then a new start clears done and the flag at the accept edge.
- Overflow boundaries:
  - 0x0001_0000 / 1 -> overflow at CHK (done E3);
  - 0x0000_8000 / 1 -> overflow at FIX (done E20);
  - 0xFFFF_8000 / 1 -> q 0x8000, r 0, no overflow;
  - 0x8000_0000 / 0x8000 -> overflow at CHK (quotient magnitude 2^16).
- Mid-operation events:
  - rst_n low during DIV -> all outputs 0 immediately, state IDLE;
  - start pulses during DIV -> ignored, original result correct;
  - start in DONE -> new operation accepted, previous result held until FIX of the new operation.
